// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int unsigned IW  = 9;
    localparam int unsigned PCW = 10;
    localparam int unsigned CW  = 16;

    typedef logic [IW-1:0]  instr_t;
    typedef logic [PCW-1:0] pc_t;
    typedef logic [CW-1:0]  cnt_t;

    localparam instr_t HALT_OP = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    // Counters stick at all-ones instead of rolling over.
    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == '1) ? c : c + CW'(1);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC select: hold on HALT, branch when taken, else increment with wrap detect.
// BRANCH_RELATIVE_EN selects a PC-relative signed target instead of an absolute one.
module pc_next_sel
    import fetch_pkg::*;
(
    input  logic [PCW-1:0] pc,
    input  logic [PCW-1:0] target,
    input  logic           taken,
    input  logic           halt,
    output logic [PCW-1:0] next_pc_c,
    output logic           wrap_c
);

    logic [PCW-1:0] branch_tgt_c;

`ifdef BRANCH_RELATIVE_EN
    // Target has full PC width, so modular addition equals adding its sign extension.
    assign branch_tgt_c = pc + target;
`else
    assign branch_tgt_c = target;
`endif

    always_comb begin
        next_pc_c = pc;
        wrap_c    = 1'b0;
        if (halt) begin
            next_pc_c = pc;
        end else if (taken) begin
            next_pc_c = branch_tgt_c;
        end else begin
            next_pc_c = pc + PCW'(1);
            wrap_c    = (pc == '1);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Program sequencer: PC register, IDLE/RUN/DONE control, sticky wrap flag and saturating counters.
// Build option BRANCH_RELATIVE_EN (handled in pc_next_sel) makes branch targets PC-relative.
module instr_fetch
    import fetch_pkg::*;
(
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Start,
    input  logic [PCW-1:0] StartAddr,
    input  logic           Stall,
    input  logic           Branch,
    input  logic           Taken,
    input  logic [PCW-1:0] Target,
    input  logic [IW-1:0]  ImemData,
    output logic [PCW-1:0] ImemAddr,
    output logic [IW-1:0]  Instr,
    output logic           InstrValid,
    output logic [PCW-1:0] PC,
    output logic           Done,
    output logic           PcWrap,
    output logic [CW-1:0]  CycleCount,
    output logic [CW-1:0]  InstrCount
);

    fetch_state_t state_q, state_d;
    pc_t          pc_q, pc_d;
    logic         wrap_q, wrap_d;
    logic         done_q, done_d;
    logic         valid_q, valid_d;
    cnt_t         cyc_q, cyc_d;
    cnt_t         icnt_q, icnt_d;

    logic         halt_c;
    pc_t          seq_pc_c;
    logic         seq_wrap_c;

    assign halt_c = (ImemData == HALT_OP);

    pc_next_sel u_pc_next_sel (
        .pc        (pc_q),
        .target    (Target),
        .taken     (Branch & Taken),
        .halt      (halt_c),
        .next_pc_c (seq_pc_c),
        .wrap_c    (seq_wrap_c)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wrap_d  = wrap_q;
        cyc_d   = cyc_q;
        icnt_d  = icnt_q;
        case (state_q)
            RUN: begin
                cyc_d = sat_inc(cyc_q);
                // A stalled cycle neither retires nor looks at the branch inputs.
                if (!Stall) begin
                    icnt_d = sat_inc(icnt_q);
                    pc_d   = seq_pc_c;
                    wrap_d = wrap_q | seq_wrap_c;
                    if (halt_c) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = StartAddr;
                    wrap_d  = 1'b0;
                    cyc_d   = '0;
                    icnt_d  = '0;
                end
            end
        endcase
        done_d  = (state_d == DONE);
        valid_d = (state_d == RUN);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            cyc_q   <= '0;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            cyc_q   <= cyc_d;
            icnt_q  <= icnt_d;
        end
    end

    assign ImemAddr   = pc_q;
    assign PC         = pc_q;
    assign Instr      = ImemData;
    assign InstrValid = valid_q;
    assign Done       = done_q;
    assign PcWrap     = wrap_q;
    assign CycleCount = cyc_q;
    assign InstrCount = icnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: branch vector table plus multi-cycle sequences.
module tb_instr_fetch;
    import fetch_pkg::*;

    logic           Clk;
    logic           Reset;
    logic           Start;
    logic [PCW-1:0] StartAddr;
    logic           Stall;
    logic           Branch;
    logic           Taken;
    logic [PCW-1:0] Target;
    logic [IW-1:0]  ImemData;
    logic [PCW-1:0] ImemAddr;
    logic [IW-1:0]  Instr;
    logic           InstrValid;
    logic [PCW-1:0] PC;
    logic           Done;
    logic           PcWrap;
    logic [CW-1:0]  CycleCount;
    logic [CW-1:0]  InstrCount;

    logic [IW-1:0]  rom [0:(1<<PCW)-1];
    assign ImemData = rom[ImemAddr];

    instr_fetch dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .StartAddr  (StartAddr),
        .Stall      (Stall),
        .Branch     (Branch),
        .Taken      (Taken),
        .Target     (Target),
        .ImemData   (ImemData),
        .ImemAddr   (ImemAddr),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .PC         (PC),
        .Done       (Done),
        .PcWrap     (PcWrap),
        .CycleCount (CycleCount),
        .InstrCount (InstrCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    int exp_pc_q[$];

    typedef struct {
        int   pc0;
        logic br;
        logic tk;
        int   tgt;
        int   exp_pc;
        logic exp_wrap;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_pc(input string name);
        int e;
        if (exp_pc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got PC %0d", name, PC);
        end else begin
            e = exp_pc_q.pop_front();
            chk(name, 32'(PC), 32'(e));
            chk({name, "_addr"}, 32'(ImemAddr), 32'(e));
        end
    endtask

    task automatic init_rom();
        for (int i = 0; i < (1 << PCW); i++) rom[i] = '1;
    endtask

    // Called just after a falling edge; returns one falling edge later with the DUT in RUN.
    task automatic start_prog(input int addr);
        Start     = 1'b1;
        StartAddr = PCW'(addr);
        @(negedge Clk);
        Start     = 1'b0;
    endtask

    initial begin
        Reset = 1'b0; Start = 1'b0; StartAddr = '0; Stall = 1'b0;
        Branch = 1'b0; Taken = 1'b0; Target = '0;
        init_rom();

`ifdef BRANCH_RELATIVE_EN
        vt[0] = '{pc0: 5,    br: 1'b1, tk: 1'b1, tgt: 10'h3FE, exp_pc: 3,    exp_wrap: 1'b0};
        vt[1] = '{pc0: 1020, br: 1'b1, tk: 1'b1, tgt: 8,       exp_pc: 4,    exp_wrap: 1'b0};
        vt[2] = '{pc0: 2,    br: 1'b1, tk: 1'b0, tgt: 9,       exp_pc: 3,    exp_wrap: 1'b0};
        vt[3] = '{pc0: 10,   br: 1'b1, tk: 1'b1, tgt: 1,       exp_pc: 11,   exp_wrap: 1'b0};
        vt[4] = '{pc0: 1022, br: 1'b0, tk: 1'b1, tgt: 7,       exp_pc: 1023, exp_wrap: 1'b0};
        vt[5] = '{pc0: 1023, br: 1'b0, tk: 1'b0, tgt: 0,       exp_pc: 0,    exp_wrap: 1'b1};
`else
        vt[0] = '{pc0: 2,    br: 1'b1, tk: 1'b1, tgt: 9,       exp_pc: 9,    exp_wrap: 1'b0};
        vt[1] = '{pc0: 2,    br: 1'b1, tk: 1'b0, tgt: 9,       exp_pc: 3,    exp_wrap: 1'b0};
        vt[2] = '{pc0: 2,    br: 1'b0, tk: 1'b1, tgt: 9,       exp_pc: 3,    exp_wrap: 1'b0};
        vt[3] = '{pc0: 1023, br: 1'b1, tk: 1'b1, tgt: 4,       exp_pc: 4,    exp_wrap: 1'b0};
        vt[4] = '{pc0: 1022, br: 1'b0, tk: 1'b0, tgt: 0,       exp_pc: 1023, exp_wrap: 1'b0};
        vt[5] = '{pc0: 1023, br: 1'b0, tk: 1'b0, tgt: 0,       exp_pc: 0,    exp_wrap: 1'b1};
`endif

        // Reset values
        @(negedge Clk);
        @(negedge Clk);
        chk("rst_pc", 32'(PC), 0);
        chk("rst_valid", 32'(InstrValid), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_cyc", 32'(CycleCount), 0);
        Reset = 1'b1;
        @(negedge Clk);
        chk("idle_valid", 32'(InstrValid), 0);

        // Straight-line program ending in HALT
        rom[0] = '0; rom[1] = '0; rom[2] = '0; rom[3] = '0;
        for (int i = 0; i < 5; i++) exp_pc_q.push_back(i);
        start_prog(0);
        for (int i = 0; i < 5; i++) begin
            check_pc("t1_pc");
            chk("t1_valid", 32'(InstrValid), 1);
            chk("t1_done_low", 32'(Done), 0);
            @(negedge Clk);
        end
        chk("t1_done", 32'(Done), 1);
        chk("t1_valid_off", 32'(InstrValid), 0);
        chk("t1_icnt", 32'(InstrCount), 5);
        chk("t1_cyc", 32'(CycleCount), 5);
        chk("t1_pc_hold", 32'(PC), 4);
        chk("t1_instr", 32'(Instr), 32'h1FF);

        // Branch / increment vector table
        for (int v = 0; v < 6; v++) begin
            init_rom();
            rom[vt[v].pc0] = '0;
            start_prog(vt[v].pc0);
            chk("tv_start_pc", 32'(PC), 32'(vt[v].pc0));
            chk("tv_start_cnt", 32'(InstrCount), 0);
            Branch = vt[v].br; Taken = vt[v].tk; Target = PCW'(vt[v].tgt);
            @(negedge Clk);
            Branch = 1'b0; Taken = 1'b0;
            chk("tv_next_pc", 32'(PC), 32'(vt[v].exp_pc));
            chk("tv_wrap", 32'(PcWrap), 32'(vt[v].exp_wrap));
            @(negedge Clk);
            chk("tv_done", 32'(Done), 1);
            chk("tv_icnt", 32'(InstrCount), 2);
        end

        // Stall held for three cycles with a pending taken branch
        init_rom();
        for (int i = 4; i < 8; i++) rom[i] = '0;
        exp_pc_q.push_back(4); exp_pc_q.push_back(5);
        for (int i = 0; i < 4; i++) exp_pc_q.push_back(6);
        exp_pc_q.push_back(20);
        start_prog(4);
        check_pc("t4_pc");
        @(negedge Clk);
        check_pc("t4_pc");
        @(negedge Clk);
        check_pc("t4_pc");
        chk("t4_icnt0", 32'(InstrCount), 2);
        chk("t4_cyc0", 32'(CycleCount), 2);
        Stall = 1'b1; Branch = 1'b1; Taken = 1'b1;
`ifdef BRANCH_RELATIVE_EN
        Target = PCW'(14);
`else
        Target = PCW'(20);
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check_pc("t4_stall_pc");
        end
        chk("t4_icnt_stall", 32'(InstrCount), 2);
        chk("t4_cyc_stall", 32'(CycleCount), 5);
        Stall = 1'b0;
        @(negedge Clk);
        Branch = 1'b0; Taken = 1'b0;
        check_pc("t4_branch_pc");
        @(negedge Clk);
        chk("t4_done", 32'(Done), 1);
        chk("t4_icnt", 32'(InstrCount), 4);
        chk("t4_cyc", 32'(CycleCount), 7);

        // Wrap past the top of program space, Start ignored in RUN, restart from DONE
        init_rom();
        rom[1023] = '0; rom[0] = '0; rom[1] = '0;
        exp_pc_q.push_back(1023); exp_pc_q.push_back(0);
        exp_pc_q.push_back(1); exp_pc_q.push_back(2);
        start_prog(1023);
        check_pc("t5_pc");
        chk("t5_wrap0", 32'(PcWrap), 0);
        @(negedge Clk);
        check_pc("t5_pc");
        chk("t5_wrap1", 32'(PcWrap), 1);
        Start = 1'b1; StartAddr = PCW'(500);
        @(negedge Clk);
        Start = 1'b0;
        check_pc("t5_ignore_pc");
        chk("t5_wrap_sticky", 32'(PcWrap), 1);
        @(negedge Clk);
        check_pc("t5_pc");
        @(negedge Clk);
        chk("t5_done", 32'(Done), 1);
        chk("t5_icnt", 32'(InstrCount), 4);
        start_prog(2);
        chk("t5_restart_pc", 32'(PC), 2);
        chk("t5_restart_wrap", 32'(PcWrap), 0);
        chk("t5_restart_done", 32'(Done), 0);
        chk("t5_restart_cyc", 32'(CycleCount), 0);
        @(negedge Clk);
        chk("t5_redone", 32'(Done), 1);
        chk("t5_reicnt", 32'(InstrCount), 1);

        // Asynchronous reset in the middle of a program
        init_rom();
        for (int i = 5; i < 10; i++) rom[i] = '0;
        start_prog(5);
        @(negedge Clk);
        @(negedge Clk);
        chk("t6_pc_pre", 32'(PC), 7);
        #2 Reset = 1'b0;
        #1;
        chk("t6_pc", 32'(PC), 0);
        chk("t6_valid", 32'(InstrValid), 0);
        chk("t6_cyc", 32'(CycleCount), 0);
        chk("t6_icnt", 32'(InstrCount), 0);
        chk("t6_done", 32'(Done), 0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("t6_idle_pc", 32'(PC), 0);
        chk("t6_idle_valid", 32'(InstrValid), 0);
        for (int i = 8; i < 11; i++) exp_pc_q.push_back(i);
        start_prog(8);
        for (int i = 0; i < 3; i++) begin
            check_pc("t6_pc_run");
            @(negedge Clk);
        end
        chk("t6_done_end", 32'(Done), 1);
        chk("t6_icnt_end", 32'(InstrCount), 3);
        chk("t6_cyc_end", 32'(CycleCount), 3);

        // CycleCount saturation under a long stall
        init_rom();
        rom[0] = '0;
        start_prog(0);
        Stall = 1'b1;
        repeat (65540) @(negedge Clk);
        chk("sat_cyc", 32'(CycleCount), 65535);
        chk("sat_icnt", 32'(InstrCount), 0);
        chk("sat_pc", 32'(PC), 0);
        Stall = 1'b0;
        @(negedge Clk);
        chk("sat_pc1", 32'(PC), 1);
        @(negedge Clk);
        chk("sat_done", 32'(Done), 1);
        chk("sat_cyc_hold", 32'(CycleCount), 65535);
        chk("sat_icnt_end", 32'(InstrCount), 2);

        chk("sb_drained", 32'(exp_pc_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
